// File: rtl/toggle_activity_monitor_if.sv
// Report stream of the toggle activity monitor: one beat per observed net, valid/ready handshake.
// The monitor drives the master modport; the consumer uses the slave modport.
interface toggle_activity_monitor_if #(
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 16
) ();
    localparam int IDX_W = $clog2(NUM_IN + 2);

    logic             rpt_valid;
    logic             rpt_ready;
    logic [IDX_W-1:0] rpt_idx;
    logic [CNT_W-1:0] rpt_data;
    logic             rpt_last;

    modport master (
        output rpt_valid,
        output rpt_idx,
        output rpt_data,
        output rpt_last,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_idx,
        input  rpt_data,
        input  rpt_last,
        output rpt_ready
    );
endinterface

// File: rtl/toggle_activity_monitor.sv
// Counts per-net toggles of a sub-circuit's inputs/output over a fixed window, then streams the counts.
// Optional macro TOGGLE_ACTIVITY_TOTAL_EN appends a saturated-sum beat after the n_out beat.
module toggle_activity_monitor #(
    parameter int NUM_IN  = 4,
    parameter int CNT_W   = 16,
    parameter int WIN_LEN = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_IN-1:0]          n_in,
    input  logic                       n_out,
    output logic                       busy,
    toggle_activity_monitor_if.master  rpt
);
    localparam int NETS  = NUM_IN + 1;
    localparam int IDX_W = $clog2(NUM_IN + 2);
    localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
`ifdef TOGGLE_ACTIVITY_TOTAL_EN
    localparam int LAST_IDX = NUM_IN + 1;
`else
    localparam int LAST_IDX = NUM_IN;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_IDX);

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NETS];
    logic [CNT_W-1:0]  cnt_d [NETS];
    logic [NETS-1:0]   prev_q, prev_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NETS-1:0]   sample;
    logic [CNT_W-1:0]  beat_data;

    // Net k of the sample vector is n_in[k]; the top bit is n_out, matching beat order.
    assign sample = {n_out, n_in};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        win_d   = win_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < NETS; k++) cnt_d[k] = '0;
                    prev_d  = sample;
                    win_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < NETS; k++) begin
                    if (sample[k] != prev_q[k] && cnt_q[k] != CNT_MAX)
                        cnt_d[k] = cnt_q[k] + 1'b1;
                end
                prev_d = sample;
                win_d  = win_q + 1'b1;
                if (win_q == WIN_LAST) begin
                    idx_d   = '0;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (rpt.rpt_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the counter array is architectural state read out after reset, so every entry is cleared explicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            win_q   <= '0;
            idx_q   <= '0;
            for (int k = 0; k < NETS; k++) cnt_q[k] <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            for (int k = 0; k < NETS; k++) cnt_q[k] <= cnt_d[k];
        end
    end

`ifdef TOGGLE_ACTIVITY_TOTAL_EN
    localparam int SUM_W = CNT_W + $clog2(NETS) + 1;
    logic [SUM_W-1:0] sum_all;
    logic [CNT_W-1:0] total_sat;

    // NOTE: blocking accumulation is correct here because this is combinational logic, not state.
    always_comb begin
        sum_all = '0;
        for (int k = 0; k < NETS; k++) sum_all = sum_all + SUM_W'(cnt_q[k]);
        total_sat = (sum_all > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_all[CNT_W-1:0];
    end
`endif

    // Counters are frozen outside RUN, so the selected beat stays stable under backpressure.
    always_comb begin
        beat_data = '0;
        for (int k = 0; k < NETS; k++) begin
            if (idx_q == IDX_W'(k)) beat_data = cnt_q[k];
        end
`ifdef TOGGLE_ACTIVITY_TOTAL_EN
        if (idx_q == IDX_W'(NUM_IN + 1)) beat_data = total_sat;
`endif
    end

    assign busy          = (state_q != IDLE);
    assign rpt.rpt_valid = (state_q == REPORT);
    assign rpt.rpt_idx   = idx_q;
    assign rpt.rpt_data  = beat_data;
    assign rpt.rpt_last  = (state_q == REPORT) && (idx_q == IDX_LAST);
endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Self-checking bench: randomized and directed windows compared against a sample-history toggle model.
// Honours TOGGLE_ACTIVITY_TOTAL_EN to expect the extra total beat.
module tb_toggle_activity_monitor;
    localparam int NUM_IN  = 4;
    localparam int CNT_W   = 4;
    localparam int WIN_LEN = 20;
    localparam int NETS    = NUM_IN + 1;
    localparam int MAXC    = (1 << CNT_W) - 1;
`ifdef TOGGLE_ACTIVITY_TOTAL_EN
    localparam int NBEATS = NUM_IN + 2;
`else
    localparam int NBEATS = NUM_IN + 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NUM_IN-1:0] n_in;
    logic              n_out;
    logic              busy;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [NETS-1:0] hist [$];
    int exp_cnt [NBEATS];

    toggle_activity_monitor_if #(.NUM_IN(NUM_IN), .CNT_W(CNT_W)) rif ();

    toggle_activity_monitor #(.NUM_IN(NUM_IN), .CNT_W(CNT_W), .WIN_LEN(WIN_LEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .n_in  (n_in),
        .n_out (n_out),
        .busy  (busy),
        .rpt   (rif.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Patterns: 0 dense random, 1 n_out every other cycle, 2 all nets every cycle,
    // 3 n_in[1] and n_out every cycle, other: sparse random flips.
    function automatic logic [NETS-1:0] next_sample(input int pat, input int c, input logic [NETS-1:0] prev);
        logic [NETS-1:0] s;
        s = '0;
        case (pat)
            0: s = NETS'($urandom);
            1: s[NUM_IN] = c[1];
            2: s = c[0] ? '1 : '0;
            3: begin
                s[NUM_IN] = c[0];
                s[1]      = c[0];
            end
            default: begin
                s = prev;
                for (int k = 0; k < NETS; k++)
                    if ($urandom_range(7) == 0) s[k] = ~s[k];
            end
        endcase
        return s;
    endfunction

    task automatic apply(input logic [NETS-1:0] s);
        n_in  = s[NUM_IN-1:0];
        n_out = s[NUM_IN];
        hist.push_back(s);
    endtask

    // Expected counts straight from the recorded samples: number of adjacent differences, clamped.
    task automatic compute_expected();
        int sum;
        for (int b = 0; b < NBEATS; b++) exp_cnt[b] = 0;
        for (int i = 0; i + 1 < hist.size(); i++)
            for (int k = 0; k < NETS; k++)
                if (hist[i][k] != hist[i+1][k]) exp_cnt[k]++;
        sum = 0;
        for (int k = 0; k < NETS; k++) begin
            if (exp_cnt[k] > MAXC) exp_cnt[k] = MAXC;
            sum += exp_cnt[k];
        end
        if (NBEATS > NETS) exp_cnt[NBEATS-1] = (sum > MAXC) ? MAXC : sum;
    endtask

    task automatic run_window(input int pat, input int stall_beat, input int stall_len, input bit extra_start);
        logic [NETS-1:0] s;
        hist.delete();
        rif.rpt_ready = 1'b1;
        s = next_sample(pat, 0, {n_out, n_in});
        apply(s);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_in_run", busy, 1);
        for (int c = 1; c <= WIN_LEN; c++) begin
            s = next_sample(pat, c, s);
            apply(s);
            start = extra_start && (c == 3);
            tick();
            check("valid_timing", rif.rpt_valid, (c == WIN_LEN));
        end
        start = 1'b0;
        compute_expected();
        for (int b = 0; b < NBEATS; b++) begin
            check("beat_valid", rif.rpt_valid, 1);
            check("beat_idx", rif.rpt_idx, b);
            check("beat_data", rif.rpt_data, exp_cnt[b]);
            check("beat_last", rif.rpt_last, (b == NBEATS - 1));
            if (b == stall_beat) begin
                rif.rpt_ready = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    start = extra_start && (j == 0);
                    tick();
                    start = 1'b0;
                    check("stall_valid", rif.rpt_valid, 1);
                    check("stall_idx", rif.rpt_idx, b);
                    check("stall_data", rif.rpt_data, exp_cnt[b]);
                end
                rif.rpt_ready = 1'b1;
            end
            tick();
        end
        check("end_busy", busy, 0);
        check("end_valid", rif.rpt_valid, 0);
        rif.rpt_ready = 1'b0;
    endtask

    initial begin
        logic [NETS-1:0] s;
        rst = 1'b1;
        start = 1'b0;
        n_in = '0;
        n_out = 1'b0;
        rif.rpt_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", rif.rpt_valid, 0);
        check("rst_idx", rif.rpt_idx, 0);
        check("rst_data", rif.rpt_data, 0);
        check("rst_last", rif.rpt_last, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_hold", busy, 0);

        run_window(1, -1, 0, 1'b0);
        run_window(2, 2, 5, 1'b0);

        // Reset in the middle of a window: nothing reported, counters back to zero.
        s = NETS'($urandom);
        apply(s);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            s = ~s;
            apply(s);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_valid", rif.rpt_valid, 0);
        check("midrst_data", rif.rpt_data, 0);
        check("midrst_last", rif.rpt_last, 0);
        tick();
        check("midrst_idle", busy, 0);

        run_window(0, 1, 3, 1'b1);
        run_window(3, NBEATS - 1, 2, 1'b0);
        for (int r = 0; r < 6; r++)
            run_window((r % 2 == 0) ? 4 : 0, $urandom_range(NBEATS - 1), $urandom_range(3), r[0]);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
